pd_file_sw_in: RTL and testbench



---
 rtl/pd_file_pio_pkg.sv | 25 ++
 rtl/pd_file_sw_in_if.sv | 11 +
 rtl/pd_file_sw_in_debounce.sv | 71 +++++++
 rtl/pd_file_sw_in.sv | 84 ++++++++
 tb/tb_pd_file_sw_in.sv | 250 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pd_file_pio_pkg.sv
// Shared definitions for the PIO register file: register addresses,
// edge-capture selections and the per-bit edge detector.
package pd_file_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_RSVD    = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Edge detect on one debounced bit, comparing it with its delayed copy.
    function automatic logic edge_detect(input logic cur, input logic prev, input int edge_type);
        logic hit;
        case (edge_type)
            EDGE_RISE: hit = cur & ~prev;
            EDGE_FALL: hit = ~cur & prev;
            default:   hit = cur ^ prev;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/pd_file_sw_in_if.sv
// Avalon-MM slave bus bundle for the switch input port.
interface pd_file_sw_in_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/pd_file_sw_in_debounce.sv
// One input line: metastability chain followed by a consecutive-sample
// debouncer. A change is accepted only after DEBOUNCE_CYCLES differing
// samples in a row; DEBOUNCE_CYCLES = 0 passes the synchronised level through.
module pd_file_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic deb_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], din_i};
    end

    assign sync = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES == 0) begin : gen_bypass
            logic deb_q;

            // No filtering: register the synchronised level directly.
            always_ff @(posedge clk) begin
                if (!reset_n) deb_q <= 1'b0;
                else          deb_q <= sync;
            end

            assign deb_o = deb_q;
        end else begin : gen_count
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          deb_q, deb_d;

            // Count consecutive disagreeing samples; accept on the last one.
            always_comb begin
                cnt_d = '0;
                deb_d = deb_q;
                if (sync != deb_q) begin
                    if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                        deb_d = sync;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end

            // Debounce state register.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    cnt_q <= '0;
                    deb_q <= 1'b0;
                end else begin
                    cnt_q <= cnt_d;
                    deb_q <= deb_d;
                end
            end

            assign deb_o = deb_q;
        end
    endgenerate

endmodule

// File: rtl/pd_file_sw_in.sv
// Avalon-MM switch/button input port: debounced level register, per-bit
// IRQ mask, write-one-to-clear edge capture and a level interrupt.
module pd_file_sw_in
    import pd_file_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    pd_file_sw_in_if.slave   bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d_q;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] wdata;
    logic             wr_en;
    logic             unused_wdata;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : gen_bit
            pd_file_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk     (clk),
                .reset_n (reset_n),
                .din_i   (in_port[gi]),
                .deb_o   (deb[gi])
            );

            assign edge_set[gi] = edge_detect(deb[gi], deb_d_q[gi], EDGE_TYPE);
        end
    endgenerate

    assign wr_en        = bus.chipselect & ~bus.write_n;
    assign wdata        = bus.writedata[WIDTH-1:0];
    // Upper write bits have no storage behind them.
    assign unused_wdata = ^bus.writedata;

    // Next state of the mask and capture registers; a new edge beats a clear.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && (bus.address == ADDR_IRQMASK)) irqmask_d = wdata;
        if (wr_en && (bus.address == ADDR_EDGECAP)) edgecap_d = edgecap_q & ~wdata;
        edgecap_d = edgecap_d | edge_set;
    end

    // Register file and delayed debounced level for edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb_d_q   <= '0;
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            deb_d_q   <= deb;
            irqmask_q <= irqmask_d;
            edgecap_q <= edgecap_d;
        end
    end

    // Zero-latency read mux, not gated by chipselect.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            ADDR_DATA:    bus.readdata = 32'(deb);
            ADDR_IRQMASK: bus.readdata = 32'(irqmask_q);
            ADDR_EDGECAP: bus.readdata = 32'(edgecap_q);
            default:      bus.readdata = '0;
        endcase
    end

    assign irq = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_pd_file_sw_in.sv
// Directed bench for pd_file_sw_in. Two instances share inputs and bus
// stimulus: dut0 captures rising edges, dut1 captures falling edges.
module tb_pd_file_sw_in;

    logic       clk;
    logic       reset_n;
    logic [7:0] in_port;
    logic       irq0, irq1;
    logic [31:0] r0, r1;
    int         vec_cnt;
    int         err_cnt;

    pd_file_sw_in_if bus0();
    pd_file_sw_in_if bus1();

    pd_file_sw_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .bus(bus0), .in_port(in_port), .irq(irq0));

    pd_file_sw_in #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(bus1), .in_port(in_port), .irq(irq1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        bus0.address = a;
        bus1.address = a;
        #1;
        r0 = bus0.readdata;
        r1 = bus1.readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        bus0.address = a;  bus0.writedata = d;  bus0.chipselect = 1'b1;  bus0.write_n = 1'b0;
        bus1.address = a;  bus1.writedata = d;  bus1.chipselect = 1'b1;  bus1.write_n = 1'b0;
        @(posedge clk);
        #1;
        bus0.chipselect = 1'b0;  bus0.write_n = 1'b1;
        bus1.chipselect = 1'b0;  bus1.write_n = 1'b1;
        $display("write addr=%0d data=%08h", a, d);
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        in_port = 8'h00;
        bus0.address = 2'd0; bus0.chipselect = 1'b0; bus0.write_n = 1'b1; bus0.writedata = '0;
        bus1.address = 2'd0; bus1.chipselect = 1'b0; bus1.write_n = 1'b1; bus1.writedata = '0;
        tick(3);
        reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a));
            vec_cnt++;
            if (r0 !== 32'h0) begin err_cnt++; $display("FAIL reset_reg%0d: got %08h want 00000000", a, r0); end
        end
        vec_cnt++;
        if (irq0 !== 1'b0) begin err_cnt++; $display("FAIL reset_irq: got %b want 0", irq0); end
        $display("test_reset done");
    endtask

    task automatic test_rise_latency;
        in_port = 8'h05;
        tick(5);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL rise_data_early: got %08h want 00000000", r0); end
        tick(1);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h05) begin err_cnt++; $display("FAIL rise_data_edge6: got %08h want 00000005", r0); end
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL rise_cap_early: got %08h want 00000000", r0); end
        tick(1);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h05) begin err_cnt++; $display("FAIL rise_cap_edge7: got %08h want 00000005", r0); end
        vec_cnt++;
        if (r1 !== 32'h00) begin err_cnt++; $display("FAIL rise_cap_falltype: got %08h want 00000000", r1); end
        vec_cnt++;
        if (irq0 !== 1'b0) begin err_cnt++; $display("FAIL rise_irq_masked: got %b want 0", irq0); end
        wr(2'd1, 32'h04);
        vec_cnt++;
        if (irq0 !== 1'b1) begin err_cnt++; $display("FAIL rise_irq_unmasked: got %b want 1", irq0); end
        rd(2'd1);
        vec_cnt++;
        if (r0 !== 32'h04) begin err_cnt++; $display("FAIL rise_mask_read: got %08h want 00000004", r0); end
    endtask

    task automatic test_w1c;
        wr(2'd2, 32'h01);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h04) begin err_cnt++; $display("FAIL w1c_bit0: got %08h want 00000004", r0); end
        vec_cnt++;
        if (irq0 !== 1'b1) begin err_cnt++; $display("FAIL w1c_irq_held: got %b want 1", irq0); end
        wr(2'd2, 32'h00);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h04) begin err_cnt++; $display("FAIL w1c_zero: got %08h want 00000004", r0); end
        wr(2'd2, 32'hFF);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL w1c_all: got %08h want 00000000", r0); end
        vec_cnt++;
        if (irq0 !== 1'b0) begin err_cnt++; $display("FAIL w1c_irq_fall: got %b want 0", irq0); end
        wr(2'd0, 32'hFF);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h05) begin err_cnt++; $display("FAIL data_write_ignored: got %08h want 00000005", r0); end
        wr(2'd3, 32'hFFFF_FFFF);
        rd(2'd3);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL addr3_read: got %08h want 00000000", r0); end
        wr(2'd1, 32'hFFFF_FF04);
        rd(2'd1);
        vec_cnt++;
        if (r0 !== 32'h04) begin err_cnt++; $display("FAIL mask_upper_bits: got %08h want 00000004", r0); end
    endtask

    task automatic test_collision;
        in_port = 8'h07;
        tick(6);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h07) begin err_cnt++; $display("FAIL coll_data: got %08h want 00000007", r0); end
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL coll_cap_pre: got %08h want 00000000", r0); end
        wr(2'd2, 32'h02);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h02) begin err_cnt++; $display("FAIL coll_set_wins: got %08h want 00000002", r0); end
        wr(2'd2, 32'h02);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL coll_clear: got %08h want 00000000", r0); end
    endtask

    task automatic test_bounce;
        in_port = 8'h06;
        tick(8);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h06) begin err_cnt++; $display("FAIL bounce_low: got %08h want 00000006", r0); end
        in_port = 8'h07;
        tick(3);
        in_port = 8'h06;
        tick(1);
        in_port = 8'h07;
        tick(5);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h06) begin err_cnt++; $display("FAIL bounce_data_held: got %08h want 00000006", r0); end
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL bounce_cap_none: got %08h want 00000000", r0); end
        tick(1);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h07) begin err_cnt++; $display("FAIL bounce_data_accept: got %08h want 00000007", r0); end
        tick(1);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h01) begin err_cnt++; $display("FAIL bounce_cap: got %08h want 00000001", r0); end
        wr(2'd2, 32'hFF);
        tick(5);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL bounce_cap_once: got %08h want 00000000", r0); end
        vec_cnt++;
        if (r1 !== 32'h00) begin err_cnt++; $display("FAIL bounce_fall_none: got %08h want 00000000", r1); end
    endtask

    task automatic test_falling;
        in_port = 8'h05;
        tick(8);
        wr(2'd2, 32'hFF);
        in_port = 8'h00;
        tick(8);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL fall_data: got %08h want 00000000", r0); end
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL fall_rise_type: got %08h want 00000000", r0); end
        vec_cnt++;
        if (r1 !== 32'h05) begin err_cnt++; $display("FAIL fall_fall_type: got %08h want 00000005", r1); end
        vec_cnt++;
        if (irq1 !== 1'b1) begin err_cnt++; $display("FAIL fall_irq1: got %b want 1", irq1); end
        vec_cnt++;
        if (irq0 !== 1'b0) begin err_cnt++; $display("FAIL fall_irq0: got %b want 0", irq0); end
    endtask

    task automatic test_reset_mid_debounce;
        in_port = 8'h05;
        tick(3);
        reset_n = 1'b0;
        tick(2);
        for (int a = 0; a < 3; a++) begin
            rd(2'(a));
            vec_cnt++;
            if (r0 !== 32'h0) begin err_cnt++; $display("FAIL midrst_reg%0d: got %08h want 00000000", a, r0); end
        end
        rd(2'd2);
        vec_cnt++;
        if (r1 !== 32'h0) begin err_cnt++; $display("FAIL midrst_cap1: got %08h want 00000000", r1); end
        vec_cnt++;
        if (irq1 !== 1'b0) begin err_cnt++; $display("FAIL midrst_irq1: got %b want 0", irq1); end
        reset_n = 1'b1;
        tick(5);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL midrst_restart: got %08h want 00000000", r0); end
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h00) begin err_cnt++; $display("FAIL midrst_no_spurious: got %08h want 00000000", r0); end
        tick(1);
        rd(2'd0);
        vec_cnt++;
        if (r0 !== 32'h05) begin err_cnt++; $display("FAIL midrst_data: got %08h want 00000005", r0); end
        tick(1);
        rd(2'd2);
        vec_cnt++;
        if (r0 !== 32'h05) begin err_cnt++; $display("FAIL midrst_release_rise: got %08h want 00000005", r0); end
        vec_cnt++;
        if (r1 !== 32'h00) begin err_cnt++; $display("FAIL midrst_release_fall: got %08h want 00000000", r1); end
    endtask

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        test_reset();
        test_rise_latency();
        test_w1c();
        test_collision();
        test_bounce();
        test_falling();
        test_reset_mid_debounce();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
